// File: rtl/shared_debounce_arbiter.sv
// rtl/shared_debounce_arbiter.sv - shared-timer push-button debouncer with round-robin grant and press counter
module shared_debounce_arbiter #(
  parameter int NUM_BTN       = 4,
  parameter int STABLE_CYCLES = 250,
  localparam int IDW          = $clog2(NUM_BTN),
  localparam int TW           = $clog2(STABLE_CYCLES)
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_state,
  output logic               evt_valid,
  output logic [IDW-1:0]     evt_id,
  input  logic               evt_ready,
  output logic               busy,
  output logic [3:0]         led
);

  typedef enum logic [1:0] {IDLE, TIMING, REPORT} state_t;

  localparam logic [TW-1:0]  TIMER_END = TW'(STABLE_CYCLES - 1);
  localparam logic [IDW-1:0] RR_INIT   = IDW'(NUM_BTN - 1);

  logic [NUM_BTN-1:0] meta_q, sync_q;
  logic [NUM_BTN-1:0] btn_state_q, btn_state_d;
  logic [NUM_BTN-1:0] req;
  state_t             state_q, state_d;
  logic [IDW-1:0]     g_q, g_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     evt_id_q, evt_id_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               evt_valid_q, evt_valid_d;
  logic               busy_q, busy_d;
  logic [3:0]         led_q, led_d;
  logic [IDW-1:0]     winner;
  logic               found;

  // Two-flop synchroniser for the asynchronous button pins
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
    end
  end

  // A button wants the timer whenever its synchronised level disagrees with its debounced level
  assign req = sync_q ^ btn_state_q;

  // Round-robin search starting just after the last winner
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_BTN;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // Next-state logic for grant, stability timing and event reporting
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    btn_state_d = btn_state_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    led_d       = led_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          g_d      = winner;
          rr_ptr_d = winner;
          timer_d  = '0;
          state_d  = TIMING;
        end
      end
      TIMING: begin
        if (sync_q[g_q] == btn_state_q[g_q]) begin
          // bounced back to the old level: abandon this grant entirely
          state_d = IDLE;
        end else if (timer_q != TIMER_END) begin
          timer_d = timer_q + TW'(1);
        end else begin
          btn_state_d[g_q] = ~btn_state_q[g_q];
          if (!btn_state_q[g_q]) begin
            // confirmed press; releases produce no event
            state_d     = REPORT;
            evt_valid_d = 1'b1;
            evt_id_d    = g_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      REPORT: begin
        if (evt_ready) begin
          evt_valid_d = 1'b0;
          led_d       = led_q + 4'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM and registered outputs
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      g_q         <= '0;
      rr_ptr_q    <= RR_INIT;
      timer_q     <= '0;
      btn_state_q <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      busy_q      <= 1'b0;
      led_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_ptr_q    <= rr_ptr_d;
      timer_q     <= timer_d;
      btn_state_q <= btn_state_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      busy_q      <= busy_d;
      led_q       <= led_d;
    end
  end

  assign btn_state = btn_state_q;
  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign busy      = busy_q;
  assign led       = led_q;

endmodule

// File: tb/tb_shared_debounce_arbiter.sv
// tb/tb_shared_debounce_arbiter.sv - directed self-checking bench for shared_debounce_arbiter
module tb_shared_debounce_arbiter;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_state;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic       busy;
  logic [3:0] led;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_ids[$];

  shared_debounce_arbiter #(.NUM_BTN(4), .STABLE_CYCLES(250)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_state (btn_state),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .busy      (busy),
    .led       (led)
  );

  always #5 sysclk = ~sysclk;

  // record every accepted event id
  always @(posedge sysclk) begin
    if (rst_n && evt_valid && evt_ready) hs_ids.push_back(int'(evt_id));
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge sysclk);
    rst_n = 1'b0; btn_raw = '0; evt_ready = 1'b0;
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (2) @(negedge sysclk);
    hs_ids.delete();
  endtask

  task automatic wait_valid(input int budget, output int cycles, output bit seen);
    cycles = 0; seen = 1'b0;
    while (!seen && cycles < budget) begin
      @(posedge sysclk); #1;
      cycles++;
      if (evt_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_raw = '0; evt_ready = 1'b0;
    #12;
    n_checks++;
    if ({btn_state, evt_valid, evt_id, busy, led} !== 12'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, expected 000", {btn_state, evt_valid, evt_id, busy, led});
    end
    @(negedge sysclk); rst_n = 1'b1;
    repeat (3) @(negedge sysclk);
    n_checks++;
    if (busy !== 1'b0 || led !== 4'd0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b led=%0d, expected busy=0 led=0", busy, led);
    end
  endtask

  task automatic test_single_press();
    int cyc; bit seen;
    do_reset();
    @(negedge sysclk); btn_raw = 4'b0001;
    @(posedge sysclk);
    wait_valid(400, cyc, seen);
    n_checks++;
    if (!seen || cyc !== 252) begin
      n_fail++; $display("FAIL press_latency: seen=%b cycles=%0d, expected 252", seen, cyc);
    end
    #1;
    n_checks++;
    if (evt_id !== 2'd0 || btn_state !== 4'b0001 || led !== 4'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL press_event: id=%0d state=%b led=%0d busy=%b, expected 0 0001 0 1", evt_id, btn_state, led, busy);
    end
    @(negedge sysclk); evt_ready = 1'b1;
    @(posedge sysclk); #1;
    n_checks++;
    if (led !== 4'd1 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL press_handshake: led=%0d valid=%b, expected 1 0", led, evt_valid);
    end
    repeat (40) @(negedge sysclk);
    hs_ids.delete();
    btn_raw = 4'b0000;
    repeat (270) @(negedge sysclk);
    n_checks++;
    if (btn_state !== 4'b0000 || hs_ids.size() !== 0 || led !== 4'd1) begin
      n_fail++; $display("FAIL release: state=%b events=%0d led=%0d, expected 0000 0 1", btn_state, hs_ids.size(), led);
    end
  endtask

  task automatic test_bounce();
    int exp_led;
    do_reset();
    evt_ready = 1'b1;
    exp_led = 0;
    for (int p = 0; p < 16; p++) begin
      int t;
      bit lvl;
      t = 0; lvl = 1'b1;
      while (t < 40) begin
        int d;
        btn_raw[0] = lvl;
        d = $urandom_range(3, 10);
        repeat (d) @(negedge sysclk);
        t += d;
        lvl = !lvl;
      end
      btn_raw[0] = 1'b1;
      repeat (300) @(negedge sysclk);
      exp_led = (exp_led + 1) % 16;
      n_checks++;
      if (led !== 4'(exp_led) || hs_ids.size() !== p + 1) begin
        n_fail++; $display("FAIL bounce_press%0d: led=%0d events=%0d, expected %0d %0d", p, led, hs_ids.size(), exp_led, p + 1);
      end
      btn_raw[0] = 1'b0;
      repeat (270) @(negedge sysclk);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    evt_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      btn_raw = 4'hF;
      repeat (1200) @(negedge sysclk);
      n_checks++;
      if (hs_ids.size() !== 4 || btn_state !== 4'hF) begin
        n_fail++; $display("FAIL simul_round%0d_count: events=%0d state=%b, expected 4 1111", r, hs_ids.size(), btn_state);
      end
      for (int i = 0; i < 4; i++) begin
        int got;
        got = (hs_ids.size() > i) ? hs_ids[i] : -1;
        n_checks++;
        if (got !== i) begin
          n_fail++; $display("FAIL simul_round%0d_order%0d: id=%0d, expected %0d", r, i, got, i);
        end
      end
      btn_raw = 4'h0;
      repeat (1200) @(negedge sysclk);
      n_checks++;
      if (btn_state !== 4'h0) begin
        n_fail++; $display("FAIL simul_round%0d_release: state=%b, expected 0000", r, btn_state);
      end
      hs_ids.delete();
    end
  endtask

  task automatic test_backpressure();
    int cyc; bit seen; bit stable;
    do_reset();
    @(negedge sysclk); btn_raw = 4'b0100;
    wait_valid(400, cyc, seen);
    n_checks++;
    if (!seen || evt_id !== 2'd2) begin
      n_fail++; $display("FAIL bp_first: seen=%b id=%0d, expected 1 2", seen, evt_id);
    end
    btn_raw = 4'b0110;
    stable = 1'b1;
    repeat (100) begin
      @(negedge sysclk);
      if (evt_valid !== 1'b1 || evt_id !== 2'd2 || led !== 4'd0 || busy !== 1'b1) stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: stable=%b valid=%b id=%0d led=%0d, expected stable 1 2 0", stable, evt_valid, evt_id, led);
    end
    evt_ready = 1'b1;
    @(posedge sysclk); #1;
    n_checks++;
    if (led !== 4'd1 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_accept: led=%0d valid=%b, expected 1 0", led, evt_valid);
    end
    wait_valid(400, cyc, seen);
    n_checks++;
    if (!seen || evt_id !== 2'd1) begin
      n_fail++; $display("FAIL bp_second: seen=%b id=%0d, expected 1 1", seen, evt_id);
    end
    @(posedge sysclk); #1;
    n_checks++;
    if (led !== 4'd2) begin
      n_fail++; $display("FAIL bp_led: led=%0d, expected 2", led);
    end
    @(negedge sysclk); btn_raw = 4'b0000;
    repeat (600) @(negedge sysclk);
    n_checks++;
    if (btn_state !== 4'b0000) begin
      n_fail++; $display("FAIL bp_release: state=%b, expected 0000", btn_state);
    end
  endtask

  task automatic test_short_press();
    evt_ready = 1'b1;
    hs_ids.delete();
    @(negedge sysclk); btn_raw = 4'b0010;
    repeat (20) @(negedge sysclk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL short_busy: busy=%b, expected 1", busy);
    end
    repeat (80) @(negedge sysclk);
    btn_raw = 4'b0000;
    repeat (10) @(negedge sysclk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL short_abort: busy=%b, expected 0", busy);
    end
    repeat (290) @(negedge sysclk);
    n_checks++;
    if (btn_state !== 4'b0000 || hs_ids.size() !== 0 || led !== 4'd2) begin
      n_fail++; $display("FAIL short_noevent: state=%b events=%0d led=%0d, expected 0000 0 2", btn_state, hs_ids.size(), led);
    end
  endtask

  task automatic test_reset_mid_timing();
    int cyc; bit seen;
    evt_ready = 1'b0;
    @(negedge sysclk); btn_raw = 4'b0001;
    @(posedge sysclk);
    repeat (122) @(posedge sysclk);
    #2;
    n_checks++;
    if (busy !== 1'b1 || led !== 4'd2) begin
      n_fail++; $display("FAIL midreset_pre: busy=%b led=%0d, expected 1 2", busy, led);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({btn_state, evt_valid, evt_id, busy, led} !== 12'h0) begin
      n_fail++; $display("FAIL midreset_async: got %h, expected 000", {btn_state, evt_valid, evt_id, busy, led});
    end
    @(negedge sysclk);
    @(negedge sysclk);
    rst_n = 1'b1;
    @(posedge sysclk);
    wait_valid(400, cyc, seen);
    n_checks++;
    if (!seen || cyc !== 252 || evt_id !== 2'd0) begin
      n_fail++; $display("FAIL midreset_latency: seen=%b cycles=%0d id=%0d, expected 1 252 0", seen, cyc, evt_id);
    end
    @(negedge sysclk); evt_ready = 1'b1;
    @(posedge sysclk); #1;
    n_checks++;
    if (led !== 4'd1) begin
      n_fail++; $display("FAIL midreset_led: led=%0d, expected 1", led);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_backpressure();
    test_short_press();
    test_reset_mid_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
